// File: rtl/gray_seq_tx_if.sv
// Symbol stream from gray_seq_tx to its consumer: data, valid/ready handshake
// and the end-of-frame marker.
interface gray_seq_tx_if;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_end;

  modport master (output out_data, output out_valid, output frame_end, input out_ready);
  modport slave  (input out_data, input out_valid, input frame_end, output out_ready);
endinterface

// File: rtl/gray_seq_tx.sv
// Burst transmitter of 4-symbol Gray frames (01,11,11,01) separated by a 00
// gap symbol, with valid/ready back-pressure, abort and a done pulse.
module gray_seq_tx (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           repeat_cnt,
  input  logic                 abort,
  gray_seq_tx_if.master        bus,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           frames_sent
);

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, GAP} state_t;

  state_t     state, state_nxt;
  logic [3:0] frames_left, frames_left_nxt;
  logic [4:0] frames_sent_nxt;
  logic       done_nxt;
  logic       hs;

  assign hs = bus.out_valid && bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      frames_left <= '0;
      frames_sent <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      frames_left <= frames_left_nxt;
      frames_sent <= frames_sent_nxt;
      done        <= done_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt       = state;
    frames_left_nxt = frames_left;
    frames_sent_nxt = frames_sent;
    done_nxt        = 1'b0;

    if (state == IDLE) begin
      if (start && !abort) begin
        state_nxt       = S0;
        frames_left_nxt = repeat_cnt;
        frames_sent_nxt = '0;
      end
    end else if (abort) begin
      // Abort wins over the handshake; the frame count stays frozen.
      state_nxt = IDLE;
    end else if (hs) begin
      case (state)
        S0:  state_nxt = S1;
        S1:  state_nxt = S2;
        S2:  state_nxt = S3;
        S3: begin
          frames_sent_nxt = frames_sent + 5'd1;
          if (frames_left == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            frames_left_nxt = frames_left - 4'd1;
            state_nxt       = GAP;
          end
        end
        GAP:     state_nxt = S0;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are pure functions of state, so they hold under back-pressure.
  always_comb begin
    case (state)
      S0:      bus.out_data = 2'b01;
      S1:      bus.out_data = 2'b11;
      S2:      bus.out_data = 2'b11;
      S3:      bus.out_data = 2'b01;
      default: bus.out_data = 2'b00;
    endcase
  end

  assign bus.out_valid = (state != IDLE);
  assign bus.frame_end = (state == S3);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_gray_seq_tx.sv
// Directed bench for gray_seq_tx: reset, bursts, back-pressure, abort,
// back-to-back start, mid-burst reset and the 16-frame boundary.
module tb_gray_seq_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] repeat_cnt;
  logic       abort;
  logic       busy;
  logic       done;
  logic [4:0] frames_sent;

  int checks   = 0;
  int failures = 0;

  gray_seq_tx_if bus ();

  gray_seq_tx dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .repeat_cnt  (repeat_cnt),
    .abort       (abort),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  // Packed view: {out_data[1:0], out_valid, frame_end, busy, done, frames_sent[4:0]}
  function automatic logic [10:0] ev(input logic [1:0] d, input logic v, input logic fe,
                                     input logic b, input logic dn, input logic [4:0] fs);
    return {d, v, fe, b, dn, fs};
  endfunction

  function automatic logic [10:0] obs();
    return {bus.out_data, bus.out_valid, bus.frame_end, busy, done, frames_sent};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for a burst already sitting in S0, ready held high:
  // per frame 01,11,11,01 then a 00 gap (except after the last frame).
  task automatic run_burst(input string tag, input int n_frames);
    logic [1:0] sym [5];
    sym[0] = 2'b01; sym[1] = 2'b11; sym[2] = 2'b11; sym[3] = 2'b01; sym[4] = 2'b00;
    for (int i = 0; i < 5 * n_frames - 1; i++) begin
      int f, pos;
      f   = i / 5;
      pos = i % 5;
      check(tag, obs(), ev(sym[pos], 1'b1, pos == 3, 1'b1, 1'b0,
                           5'(f + ((pos == 4) ? 1 : 0))));
      tick();
    end
    check({tag, "_done"}, obs(), ev(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'(n_frames)));
  endtask

  initial begin
    rst           = 1'b0;
    start         = 1'b0;
    repeat_cnt    = 4'd0;
    abort         = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held two cycles, then released
    tick();
    check("rst_c1", obs(), ev(2'b00, 0, 0, 0, 0, 5'd0));
    tick();
    check("rst_c2", obs(), ev(2'b00, 0, 0, 0, 0, 5'd0));
    rst = 1'b1;
    tick();
    check("rst_rel", obs(), ev(2'b00, 0, 0, 0, 0, 5'd0));

    // Single frame
    start = 1'b1; repeat_cnt = 4'd0; bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    run_burst("one_frame", 1);
    tick();
    check("one_frame_after", obs(), ev(2'b00, 0, 0, 0, 0, 5'd1));

    // Three frames, then a new burst started in the done cycle
    start = 1'b1; repeat_cnt = 4'd2;
    tick();
    start = 1'b0;
    run_burst("three_frame", 3);
    start = 1'b1; repeat_cnt = 4'd0;
    tick();
    start = 1'b0;
    check("b2b_s0", obs(), ev(2'b01, 1, 0, 1, 0, 5'd0));
    tick(); tick(); tick();
    check("b2b_s3", obs(), ev(2'b01, 1, 1, 1, 0, 5'd0));
    tick();
    check("b2b_done", obs(), ev(2'b00, 0, 0, 0, 1, 5'd1));

    // Back-pressure in S1 for three cycles, then in S3 for one
    start = 1'b1; repeat_cnt = 4'd0;
    tick();
    start = 1'b0;
    tick();
    check("bp_s1", obs(), ev(2'b11, 1, 0, 1, 0, 5'd0));
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_s1", obs(), ev(2'b11, 1, 0, 1, 0, 5'd0));
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_s2", obs(), ev(2'b11, 1, 0, 1, 0, 5'd0));
    tick();
    bus.out_ready = 1'b0;
    check("bp_s3", obs(), ev(2'b01, 1, 1, 1, 0, 5'd0));
    tick();
    check("bp_hold_s3", obs(), ev(2'b01, 1, 1, 1, 0, 5'd0));
    bus.out_ready = 1'b1;
    tick();
    check("bp_done", obs(), ev(2'b00, 0, 0, 0, 1, 5'd1));

    // Abort in GAP of a 4-frame burst
    start = 1'b1; repeat_cnt = 4'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("ab_gap", obs(), ev(2'b00, 1, 0, 1, 0, 5'd1));
    abort = 1'b1;
    tick();
    check("ab_idle", obs(), ev(2'b00, 0, 0, 0, 0, 5'd1));
    abort = 1'b0;
    tick();
    check("ab_no_done", obs(), ev(2'b00, 0, 0, 0, 0, 5'd1));
    start = 1'b1; abort = 1'b1;
    tick();
    check("ab_start_both", obs(), ev(2'b00, 0, 0, 0, 0, 5'd1));
    abort = 1'b0;
    tick();
    check("ab_restart", obs(), ev(2'b01, 1, 0, 1, 0, 5'd0));

    // Start held high while busy (ignored), then reset in S2 of frame 2
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    check("rs_s2", obs(), ev(2'b11, 1, 0, 1, 0, 5'd1));
    start = 1'b0;
    rst = 1'b0;
    tick();
    check("rs_mid", obs(), ev(2'b00, 0, 0, 0, 0, 5'd0));
    rst = 1'b1;
    tick();
    check("rs_no_done", obs(), ev(2'b00, 0, 0, 0, 0, 5'd0));

    // Boundary: repeat_cnt=15 gives 16 frames, frames_sent reaches 16
    start = 1'b1; repeat_cnt = 4'd15;
    tick();
    start = 1'b0;
    run_burst("max_burst", 16);
    tick();
    check("max_after", obs(), ev(2'b00, 0, 0, 0, 0, 5'd16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_seq_tx.md
GRAY_SEQ_TX -- requirements
Module: gray_seq_tx

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-003 SHALL have port start  input  1  request to transmit a burst; sampled only in IDLE.
REQ-004 SHALL have port repeat_cnt  input  4  burst length; burst = repeat_cnt+1 frames; captured when start is accepted.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a burst in progress.
REQ-006 SHALL have port out_ready  input  1  downstream accepts the current symbol.
REQ-007 SHALL have port out_data  output  2  current symbol.
REQ-008 SHALL have port out_valid  output  1  out_data holds a symbol to transfer.
REQ-009 SHALL have port frame_end  output  1  high while the last symbol of a frame is presented.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal burst completion.
REQ-012 SHALL have port frames_sent  output  5  count of completed frames in the current or last burst.

Function
REQ-013 SHALL implement states IDLE, S0, S1, S2, S3, GAP; out_data per state: IDLE=00, S0=01, S1=11, S2=11, S3=01, GAP=00.
REQ-014 SHALL assert out_valid in S0..S3 and GAP, deassert in IDLE.
REQ-015 SHALL define a handshake as out_valid && out_ready at a rising edge; state advances only on a handshake, otherwise holds.
REQ-016 SHALL keep out_data and frame_end stable while out_valid && !out_ready.
REQ-017 SHALL, in IDLE with start=1 and abort=0, load frames_left<=repeat_cnt, clear frames_sent to 0, and enter S0; first symbol valid one cycle after start is sampled.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL transition S0->S1->S2->S3 on successive handshakes.
REQ-020 SHALL, on handshake in S3, increment frames_sent; if frames_left==0, enter IDLE and pulse done next cycle; else decrement frames_left and enter GAP.
REQ-021 SHALL, on handshake in GAP, enter S0.
REQ-022 SHALL drive frame_end = 1 only in S3 (combinational from state), independent of out_ready.
REQ-023 SHALL give abort priority over handshake and start: abort=1 in any non-IDLE state -> IDLE next cycle, out_valid=0, no done pulse, frames_sent frozen.
REQ-024 SHALL ignore abort in IDLE; start and abort together in IDLE -> remain IDLE.
REQ-025 SHALL make done registered: high exactly the cycle after the final S3 handshake, busy=0 that same cycle.
REQ-026 SHALL allow start in the cycle done is high (state already IDLE), beginning a new burst with no idle gap.
REQ-027 SHALL saturate nothing: repeat_cnt=15 yields 16 frames, frames_sent reaches 16 without wrap.
REQ-028 SHALL produce, with out_ready held high, one symbol per cycle: burst of N+1 frames takes 5(N+1)-1 cycles from first S0 to last S3.

Reset
REQ-029 SHALL, when rst=0 at a rising edge, force state=IDLE, frames_left=0, frames_sent=0, done=0; hence out_valid=0, out_data=00, frame_end=0, busy=0.
REQ-030 SHALL let reset override start, abort and handshake, including mid-burst; no done pulse results.

Verification
REQ-031 SHALL cover: rst=0 two cycles, then rst=1 -> all outputs zero, out_data=00.
REQ-032 SHALL cover: start, repeat_cnt=0, out_ready=1 -> out_data 01,11,11,01 on four consecutive cycles, frame_end on 4th, done next cycle, frames_sent=1.
REQ-033 SHALL cover: repeat_cnt=2, out_ready=1 -> 01,11,11,01,00,01,11,11,01,00,01,11,11,01 then done; frames_sent=3.
REQ-034 SHALL cover: out_ready=0 for 3 cycles while in S1 -> out_data held 11, valid held, state unchanged; resumes to S2 on ready.
REQ-035 SHALL cover: abort during GAP of a 4-frame burst -> IDLE next cycle, no done, frames_sent=1 retained; new start clears it to 0.
REQ-036 SHALL cover: rst=0 while in S2 with out_ready=1 -> IDLE, frames_sent=0, no done; start during busy ignored.
